// File: rtl/qconv_pkg.sv
// Shared qconv definitions: default widths and walker state encoding.
package qconv_pkg;

  localparam int unsigned HBitWidth = 8;
  localparam int unsigned WBitWidth = 8;
  localparam int unsigned AddrWidth = 16;

  localparam logic [1:0] IHW_STATE_IDLE = 2'd0;
  localparam logic [1:0] IHW_STATE_LOAD = 2'd1;
  localparam logic [1:0] IHW_STATE_RUN  = 2'd2;
  localparam logic [1:0] IHW_STATE_DONE = 2'd3;

  typedef enum logic [1:0] {
    IHW_IDLE = IHW_STATE_IDLE,
    IHW_LOAD = IHW_STATE_LOAD,
    IHW_RUN  = IHW_STATE_RUN,
    IHW_DONE = IHW_STATE_DONE
  } ihw_state_e;

endpackage

// File: rtl/qconv_loop_counter.sv
// Loop index counter: clear, increment-on-enable, flag when index is limit-1.
module qconv_loop_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [Width-1:0] limit,
  output logic             is_last_c
);

  logic [Width-1:0] idx_q;

  // Index register; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + Width'(1);
    end
  end

  assign is_last_c = (idx_q == (limit - Width'(1)));

endmodule

// File: rtl/qconv_ihw_walker.sv
// Input height x width raster walker: emits one buffer address per position
// over valid/ready, then pulses finish back to the controller.
module qconv_ihw_walker
  import qconv_pkg::*;
#(
  parameter int unsigned HBitWidth = qconv_pkg::HBitWidth,
  parameter int unsigned WBitWidth = qconv_pkg::WBitWidth,
  parameter int unsigned AddrWidth = qconv_pkg::AddrWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [HBitWidth-1:0] cfg_height,
  input  logic [WBitWidth-1:0] cfg_width,
  input  logic [AddrWidth-1:0] cfg_base,
  input  logic [AddrWidth-1:0] cfg_stride,
  output logic [AddrWidth-1:0] addr,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic                 busy,
  output logic                 finish
);

  ihw_state_e state_q, state_d;

  logic [HBitWidth-1:0] height_q;
  logic [WBitWidth-1:0] width_q;
  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] stride_q;

  logic [AddrWidth-1:0] row_q, row_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 finish_q, finish_d;

  logic cap;
  logic w_clr, w_inc, w_last;
  logic h_clr, h_inc, h_last;

  // Inner (column) index.
  qconv_loop_counter #(.Width(WBitWidth)) u_w_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .inc       (w_inc),
    .limit     (width_q),
    .is_last_c (w_last)
  );

  // Outer (row) index.
  qconv_loop_counter #(.Width(HBitWidth)) u_h_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (h_clr),
    .inc       (h_inc),
    .limit     (height_q),
    .is_last_c (h_last)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IHW_IDLE;
      row_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  // Descriptor capture, only on a start accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      height_q <= '0;
      width_q  <= '0;
      base_q   <= '0;
      stride_q <= '0;
    end else if (cap) begin
      height_q <= cfg_height;
      width_q  <= cfg_width;
      base_q   <= cfg_base;
      stride_q <= cfg_stride;
    end
  end

  // Next-state, next-output and counter control.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    finish_d = 1'b0;
    cap      = 1'b0;
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    h_clr    = 1'b0;
    h_inc    = 1'b0;

    unique case (state_q)
      IHW_IDLE: begin
        if (start) begin
          state_d = IHW_LOAD;
          cap     = 1'b1;
        end
      end
      IHW_LOAD: begin
        w_clr  = 1'b1;
        h_clr  = 1'b1;
        row_d  = base_q;
        addr_d = base_q;
        if ((height_q == '0) || (width_q == '0)) begin
          state_d  = IHW_DONE;
          finish_d = 1'b1;
        end else begin
          state_d = IHW_RUN;
          valid_d = 1'b1;
        end
      end
      IHW_RUN: begin
        if (valid_q && addr_ready) begin
          if (!w_last) begin
            w_inc  = 1'b1;
            addr_d = addr_q + AddrWidth'(1);
          end else if (!h_last) begin
            w_clr  = 1'b1;
            h_inc  = 1'b1;
            row_d  = row_q + stride_q;
            addr_d = row_q + stride_q;
          end else begin
            valid_d  = 1'b0;
            state_d  = IHW_DONE;
            finish_d = 1'b1;
          end
        end
      end
      IHW_DONE: begin
        state_d = IHW_IDLE;
      end
      default: begin
        state_d = IHW_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IHW_IDLE);
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_qconv_ihw_walker.sv
// Bench for qconv_ihw_walker: descriptor table plus random walks against a
// nested-loop address model, and a mid-walk reset sequence.
module tb_qconv_ihw_walker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_height = '0;
  logic [7:0]  cfg_width = '0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_stride = '0;
  logic [15:0] addr;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        busy;
  logic        finish;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          h;
    int          w;
    logic [15:0] base;
    logic [15:0] stride;
    int          mode;     // 0: ready=1, 1: ready 1,0,0 repeating, 2: random
    bit          inject;   // re-pulse start in RUN and in the DONE cycle
    int          exp_n;
    logic [15:0] exp_last;
  } vec_t;

  qconv_ihw_walker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_height (cfg_height),
    .cfg_width  (cfg_width),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Runs one walk; the expected address list comes from nested row/column loops.
  task automatic run_walk(input vec_t v);
    logic [15:0] exp_q[$];
    logic [15:0] prev_addr;
    logic [15:0] last_addr;
    logic        prev_stall;
    logic        r;
    int n, hs, first_v, fin_n, fin_cnt, last_hs;

    for (int i = 0; i < v.h; i++)
      for (int j = 0; j < v.w; j++)
        exp_q.push_back(16'(32'(v.base) + i * 32'(v.stride) + j));

    cfg_height = 8'(v.h);
    cfg_width  = 8'(v.w);
    cfg_base   = v.base;
    cfg_stride = v.stride;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    n = 0; hs = 0; first_v = -1; fin_n = -1; fin_cnt = 0; last_hs = -1;
    prev_stall = 1'b0; prev_addr = '0; last_addr = '0;
    chk("load_valid_low", 32'(addr_valid), 0);

    while (n < 2000) begin
      case (v.mode)
        0:       r = 1'b1;
        1:       r = (n % 3 == 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      addr_ready = r;
      cfg_height = 8'($urandom);
      cfg_width  = 8'($urandom);
      cfg_base   = 16'($urandom);
      cfg_stride = 16'($urandom);

      if (addr_valid) begin
        if (first_v < 0) first_v = n;
        if (prev_stall) chk("stall_addr_stable", 32'(addr), 32'(prev_addr));
      end
      if (finish) begin
        fin_cnt++;
        if (fin_n < 0) fin_n = n;
        chk("finish_excl_valid", 32'(addr_valid), 0);
      end
      if (fin_n < 0 || n == fin_n) chk("busy_high", 32'(busy), 1);
      else chk("busy_low_after", 32'(busy), 0);

      if (addr_valid && r) begin
        if (hs < exp_q.size()) chk("addr_seq", 32'(addr), 32'(exp_q[hs]));
        else chk("extra_handshake", 32'(hs), 32'(exp_q.size()));
        hs++;
        last_hs = n;
        last_addr = addr;
      end
      prev_stall = addr_valid && !r;
      prev_addr  = addr;

      start = v.inject && (n == 3 || n == fin_n);

      if (fin_n >= 0 && n == fin_n + 2) break;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    addr_ready = 1'b0;

    chk("finish_seen", 32'(fin_n >= 0), 1);
    chk("handshake_count", 32'(hs), 32'(v.exp_n));
    chk("finish_count", 32'(fin_cnt), 1);
    if (v.exp_n > 0) begin
      chk("first_valid_latency", 32'(first_v), 1);
      chk("finish_latency", 32'(fin_n), 32'(last_hs + 1));
      chk("last_addr", 32'(last_addr), 32'(v.exp_last));
    end else begin
      chk("no_valid", 32'(first_v), 32'(-1));
      chk("zero_finish_latency", 32'(fin_n), 1);
    end
  endtask

  initial begin
    vec_t tbl[10];
    vec_t rv;
    tbl[0] = '{2, 3, 16'h0100, 16'h0010, 0, 1'b0, 6, 16'h0112};
    tbl[1] = '{2, 3, 16'h0100, 16'h0010, 1, 1'b0, 6, 16'h0112};
    tbl[2] = '{0, 5, 16'h0200, 16'h0001, 0, 1'b0, 0, 16'h0000};
    tbl[3] = '{1, 4, 16'hFFFE, 16'h0000, 0, 1'b0, 4, 16'h0001};
    tbl[4] = '{2, 3, 16'h0100, 16'h0010, 0, 1'b1, 6, 16'h0112};
    tbl[5] = '{3, 2, 16'h1000, 16'h0100, 2, 1'b0, 6, 16'h1201};
    tbl[6] = '{4, 1, 16'hFFF0, 16'h0008, 2, 1'b0, 4, 16'h0008};
    tbl[7] = '{5, 0, 16'h0300, 16'h0004, 2, 1'b0, 0, 16'h0000};
    tbl[8] = '{1, 255, 16'h0000, 16'h0000, 0, 1'b0, 255, 16'h00FE};
    tbl[9] = '{255, 1, 16'h0000, 16'h0100, 0, 1'b0, 255, 16'hFE00};

    #12;
    chk("rst_addr", 32'(addr), 0);
    chk("rst_valid", 32'(addr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finish", 32'(finish), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) run_walk(tbl[k]);

    for (int k = 0; k < 8; k++) begin
      rv.h = int'($urandom_range(0, 4));
      rv.w = int'($urandom_range(0, 4));
      rv.base = 16'($urandom);
      rv.stride = 16'($urandom);
      rv.mode = 2;
      rv.inject = 1'($urandom_range(0, 1)) && (rv.h * rv.w >= 4);
      rv.exp_n = rv.h * rv.w;
      rv.exp_last = 16'(32'(rv.base) + (rv.h - 1) * 32'(rv.stride) + (rv.w - 1));
      run_walk(rv);
    end

    // Reset in the middle of a walk, after three handshakes.
    cfg_height = 8'd2; cfg_width = 8'd3; cfg_base = 16'h0100; cfg_stride = 16'h0010;
    addr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_addr", 32'(addr), 32'h0110);
    chk("pre_reset_valid", 32'(addr_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_addr", 32'(addr), 0);
    chk("async_rst_valid", 32'(addr_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_finish", 32'(finish), 0);
    addr_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold_finish", 32'(finish), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_finish", 32'(finish), 0);
    rv = '{1, 1, 16'h0ABC, 16'h1234, 0, 1'b0, 1, 16'h0ABC};
    run_walk(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qconv_ihw_walker.md
Name: qconv_ihw_walker

Overview:
- Responder side of the qconv start/finish loop protocol: a real replacement for the stub sub-state-machine that the OcHigh controller triggers.
- On a one-cycle start pulse it samples a tile descriptor and walks input height x width in raster order.
- For each position it emits one address over a valid/ready handshake to the input-buffer reader, then pulses finish.
- Sits between the qconv_states controller and the input activation fetch path.

Parameters:
HBitWidth, 8, width of height count/index
WBitWidth, 8, width of width count/index
AddrWidth, 16, width of emitted buffer address

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle trigger from controller; honoured only in IDLE
cfg_height  in  HBitWidth  rows to walk; sampled on accepted start
cfg_width  in  WBitWidth  columns to walk; sampled on accepted start
cfg_base  in  AddrWidth  address of (0,0); sampled on accepted start
cfg_stride  in  AddrWidth  address delta between rows; sampled on accepted start
addr  out  AddrWidth  current address
addr_valid  out  1  addr valid
addr_ready  in  1  consumer accepts addr when valid && ready
busy  out  1  high from LOAD through DONE inclusive
finish  out  1  one-cycle pulse on walk completion

Behaviour:
- Reset (async assert, sync-deassert-safe): state=IDLE; addr=0, addr_valid=0, busy=0, finish=0; all counters and config regs 0.
- States:
  - IDLE: start=1 -> LOAD; config regs capture cfg_* on that edge.
  - LOAD (1 cycle): h=0, w=0, row_addr=base, addr=base. If height==0 or width==0 -> DONE, no addr emitted; else -> RUN with addr_valid=1.
  - RUN: addr_valid held high; addr must not change while valid && !ready. On handshake:
    - if w<width-1: w++, addr++.
    - else if h<height-1: w=0, h++, row_addr+=stride, addr=row_addr+stride.
    - else: addr_valid=0 -> DONE.
    - Back-to-back handshakes give 1 address/cycle.
  - DONE (1 cycle): finish=1 -> IDLE.
- Latency:
  - start to first addr_valid: 2 cycles.
  - Last handshake to finish: 1 cycle.
  - Zero-size walk: finish 2 cycles after start.
- Arithmetic: address sums are modulo 2^AddrWidth, wrapping silently. No multiplier; the row address is accumulated.
- start outside IDLE (including in the DONE cycle) is ignored and must not disturb the walk or the captured config.
- cfg_* changes after capture have no effect.
- addr_ready while addr_valid=0 is ignored.
- Reset mid-walk: immediate return to IDLE, outputs to reset values, no finish pulse.
- busy = (state != IDLE). finish is never high in the same cycle as addr_valid.
- Total handshakes per walk = height*width exactly.

Decomposition:
- Shared package qconv_pkg holds:
  - state encoding constants IHW_STATE_IDLE/LOAD/RUN/DONE;
  - default widths HBitWidth/WBitWidth/AddrWidth, shared with qconv_states and sibling walkers (thresholds, outputs).
- One natural sub-module: qconv_loop_counter, a parameterised index counter with clear, increment-on-enable and is_last flag, instantiated twice (w inner, h outer).

Test Plan:
- height=2, width=3, base=0x0100, stride=0x0010, ready tied 1 -> addrs 0x0100,0x0101,0x0102,0x0110,0x0111,0x0112 on consecutive cycles; finish one cycle after the last; busy drops the same cycle finish falls.
- Same config, ready toggling 1,0,0,1,... -> same 6-address sequence, addr stable during stalls, exactly 6 handshakes, single finish pulse.
- height=0, width=5 -> no addr_valid; finish pulse 2 cycles after start.
- base=0xFFFE, height=1, width=4, stride=0 -> addrs 0xFFFE,0xFFFF,0x0000,0x0001 (wrap).
- start re-pulsed in RUN and in the DONE cycle with a different cfg -> ignored; original sequence and one finish only; a new start in IDLE then runs the new cfg.
- rst_n asserted mid-RUN after 3 handshakes -> outputs go to 0 asynchronously, no finish; after release, start with height=1, width=1 -> one addr = cfg_base, then finish.
